// File: rtl/u_serial_sub.sv
// Bit-serial unsigned ripple-borrow subtractor: a - b, one bit per clock, LSB first.
// Optional macro U_SERIAL_SUB_SAT_EN clamps a borrowing result to {1'b1, N'b0}.
module u_serial_sub #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   u_serial_sub_out
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      res_q, res_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              diff_bit;
  logic              borrow_next;

  // One full-subtractor cell on the operand LSBs.
  assign diff_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Result fills from the MSB side so bit 0 lands at res[0] after N shifts.
        res_d        = res_q >> 1;
        res_d[N-1]   = diff_bit;
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        br_d         = borrow_next;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready         = (state_q == StIdle);
    out_valid        = (state_q == StDone);
    u_serial_sub_out = '0;
    if (state_q == StDone) begin
`ifdef U_SERIAL_SUB_SAT_EN
      u_serial_sub_out = br_q ? {1'b1, {N{1'b0}}} : {1'b0, res_q};
`else
      u_serial_sub_out = {br_q, res_q};
`endif
    end
  end

endmodule

// File: tb/tb_u_serial_sub.sv
// Scoreboard bench for u_serial_sub (N=4): directed cases, backpressure, mid-run reset,
// and all 256 operand pairs with random stalls.
module tb_u_serial_sub;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   dout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N:0] exp_q[$];
  bit   rand_ready  = 1'b0;
  bit   ready_fixed = 1'b1;

  u_serial_sub #(.N(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a                (a),
    .b                (b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .u_serial_sub_out (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] r;
    r = {1'b0, x} - {1'b0, y};
`ifdef U_SERIAL_SUB_SAT_EN
    if (r[N]) r = {1'b1, {N{1'b0}}};
`endif
    return r;
  endfunction

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(dout), 32'h0);
      else check("result", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  // out_ready driver: fixed level or random stalls.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // All main-thread actions happen #1 after a rising edge.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input bit push,
                      input int idle);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        check("accept_timeout", 32'h0, 32'h1);
        break;
      end
    end
    in_valid = 1'b0;
    if (acc && push) exp_q.push_back(ref_sub(x, y));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int lat;
    logic [N:0] held;
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out", 32'(dout), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency: out_valid visible after the N-th edge following accept
    send(4'd9, 4'd3, 1'b1, 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'(N));
    check("out_9_3", 32'(dout), 32'h06);
    drain();

    // Directed and boundary pairs
    send(4'd3, 4'd9, 1'b1, 0);
    drain();
    send(4'd0, 4'd0, 1'b1, 0);
    send(4'd15, 4'd15, 1'b1, 0);
    send(4'd0, 4'd15, 1'b1, 0);
    send(4'd15, 4'd0, 1'b1, 0);
    drain();

    // Backpressure: hold in DONE while a new pair is offered
    ready_fixed = 1'b0;
    @(posedge clk);
    #1;
    send(4'd3, 4'd9, 1'b1, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    held = ref_sub(4'd3, 4'd9);
    in_valid = 1'b1;
    a = 4'd7;
    b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_held", 32'(dout), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    drain();
    @(posedge clk);
    #1;
    check("bp_in_ready_after", 32'(in_ready), 32'h1);
    send(4'd7, 4'd1, 1'b1, 0);
    drain();

    // Reset mid-RUN at counter = 2: nothing emitted
    send(4'd12, 4'd5, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(out_valid), 32'h0);
    send(4'd1, 4'd2, 1'b1, 0);
    drain();

    // Exhaustive with random stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(4'(i >> 4), 4'(i), 1'b1, int'($urandom_range(0, 2)));
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
